// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the serial pulse receiver:
//   state_e             - receiver FSM states (IDLE, SHIFT, PARITY)
//   PULSE_WIDTH_DEFAULT - default number of data bits per frame
//   cnt_width()         - width of the bit counter for a given frame width
// The PARITY state only exists in builds that define PULSE_RECEIVER_PARITY_EN.
// -----------------------------------------------------------------------------
package pulse_pkg;

  localparam int PULSE_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // The counter must hold 0..WIDTH. WIDTH is only reached when a parity bit follows the data.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in, parallel-out shift register with synchronous clear and enable.
// MSB_FIRST=1: bits enter at bit 0 and move towards the MSB, so the first bit
//              shifted in ends up in word[WIDTH-1] after WIDTH shifts.
// MSB_FIRST=0: bits enter at the MSB and move towards bit 0, so the first bit
//              ends up in word[0].
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears the register
//   clr_i   - synchronous clear (has priority over en_i)
//   en_i    - shift bit_i in on this edge
//   bit_i   - serial input bit
//   word_o  - register contents as they will be after this edge. This value
//             includes the bit being shifted in now, so the consumer can
//             capture a complete word on the same edge that takes its last bit.
// -----------------------------------------------------------------------------
module sipo_shift_reg
  import pulse_pkg::*;
#(
  parameter int WIDTH     = PULSE_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] data_q, data_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      if (MSB_FIRST) begin
        data_d = {data_q[WIDTH-2:0], bit_i};
      end else begin
        data_d = {bit_i, data_q[WIDTH-1:1]};
      end
    end
  end

  assign word_o = data_d;

  // NOTE: state registers use non-blocking assignments, so every flop samples its pre-edge inputs.
  // NOTE: this is a single register, not a memory array, so it takes the asynchronous reset like any other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pulse_receiver.sv
// -----------------------------------------------------------------------------
// pulse_receiver
// Receives one serial frame per start strobe, one bit per clock, and presents
// the assembled parallel word with a valid/ack handshake.
//
// Timing: if start is sampled at edge N, data bits are sampled at edges
// N+1..N+WIDTH. The frame completes on the last of those edges, or at edge
// N+WIDTH+1 when a parity bit follows the data.
//
// Optional feature, macro PULSE_RECEIVER_PARITY_EN: an even-parity bit follows
// the data (PARITY state), and the parity_err output is added.
//
// Ports:
//   Clk        - clock, rising edge
//   Reset      - asynchronous active-low reset
//   start      - one-cycle frame-start strobe; while a frame is in progress it
//                aborts that frame and starts a new one
//   pulse      - serial data, one bit per cycle
//   ack        - consumer acknowledge of the presented word
//   value      - last accepted parallel word
//   valid      - value holds a word that has not been acknowledged
//   busy       - a frame is being shifted in
//   overrun    - sticky: a completed frame was dropped because valid was still high
//   parity_err - (parity builds only) parity check result of the last loaded word
// -----------------------------------------------------------------------------
module pulse_receiver
  import pulse_pkg::*;
#(
  parameter int WIDTH     = PULSE_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             pulse,
  input  logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             busy,
  output logic             overrun
`ifdef PULSE_RECEIVER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef PULSE_RECEIVER_PARITY_EN
  logic             perr_q, perr_d;
`endif

  logic             sr_clr;
  logic             sr_en;
  logic             done;
  logic [WIDTH-1:0] word;

  sipo_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sipo (
    .clk_i (Clk),
    .rst_ni(Reset),
    .clr_i (sr_clr),
    .en_i  (sr_en),
    .bit_i (pulse),
    .word_o(word)
  );

  // Frame sequencing. A start seen while a frame is in progress restarts the
  // frame from bit 0 and suppresses completion, even on the last-bit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_d  = '0;
          sr_clr = 1'b1;
        end else begin
          sr_en = 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef PULSE_RECEIVER_PARITY_EN
            state_d = PARITY;
            cnt_d   = cnt_q + 1'b1;
`else
            state_d = IDLE;
            cnt_d   = '0;
            done    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef PULSE_RECEIVER_PARITY_EN
      PARITY: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end else begin
          // The shifter is idle here, so word already holds the complete data.
          state_d = IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake. On completion, the new word is loaded if the slot is free or
  // is being acknowledged on this same edge. Otherwise the word is dropped
  // and overrun is set. A plain acknowledge frees the slot and clears overrun.
  always_comb begin
    value_d   = value_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef PULSE_RECEIVER_PARITY_EN
    perr_d    = perr_q;
`endif
    if (done) begin
      if (!valid_q || ack) begin
        value_d = word;
        valid_d = 1'b1;
`ifdef PULSE_RECEIVER_PARITY_EN
        perr_d  = ^word ^ pulse;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PULSE_RECEIVER_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PULSE_RECEIVER_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);
`ifdef PULSE_RECEIVER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_pulse_receiver.sv
// -----------------------------------------------------------------------------
// tb_pulse_receiver
// Directed bench for pulse_receiver with WIDTH=8 and MSB_FIRST=1. Inputs change
// 1 time unit after each rising edge, and outputs are sampled at that same point.
// Builds with PULSE_RECEIVER_PARITY_EN also cover the parity frame.
// -----------------------------------------------------------------------------
module tb_pulse_receiver;

  localparam int WIDTH = 8;
`ifdef PULSE_RECEIVER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic             start;
  logic             pulse;
  logic             ack;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             busy;
  logic             overrun;
`ifdef PULSE_RECEIVER_PARITY_EN
  logic             parity_err;
  logic             flip_par;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  pulse_receiver #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(1'b1)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (start),
    .pulse  (pulse),
    .ack    (ack),
    .value  (value),
    .valid  (valid),
    .busy   (busy),
    .overrun(overrun)
`ifdef PULSE_RECEIVER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Shift the data bits (MSB first), plus the parity bit in parity builds.
  // When ack_last is set, ack is raised on the completion edge.
  task automatic shift_bits(input logic [7:0] data, input logic ack_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      pulse = data[i];
`ifndef PULSE_RECEIVER_PARITY_EN
      if (i == 0) ack = ack_last;
`endif
      tick();
    end
`ifdef PULSE_RECEIVER_PARITY_EN
    pulse = ^data ^ flip_par;
    ack   = ack_last;
    tick();
`endif
    ack   = 1'b0;
    pulse = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic ack_last);
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_bits(data, ack_last);
  endtask

  task automatic ack_once();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    int         busy_cycles;

    Reset = 1'b0;
    start = 1'b0;
    pulse = 1'b0;
    ack   = 1'b0;
`ifdef PULSE_RECEIVER_PARITY_EN
    flip_par = 1'b0;
`endif
    #1;
    check("rst_value",   32'(value),   32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    tick();
    tick();
    Reset = 1'b1;

    // Basic frame 0xA5: busy for FRAME_LEN cycles, valid on the cycle after that.
    a5          = 8'hA5;
    busy_cycles = 0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (busy) busy_cycles++;
      check("a5_valid_low", 32'(valid), 32'h0);
      pulse = (k < WIDTH) ? a5[WIDTH-1-k] : ^a5;
      tick();
    end
    pulse = 1'b0;
    check("a5_busy_cycles", 32'(busy_cycles), 32'(FRAME_LEN));
    check("a5_value", 32'(value), 32'hA5);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_busy_done", 32'(busy), 32'h0);
    ack_once();
    check("a5_ack_valid", 32'(valid), 32'h0);
    ack_once();
    check("ack_idle_valid",   32'(valid),   32'h0);
    check("ack_idle_overrun", 32'(overrun), 32'h0);

    // Overrun: 0x3C is left unacknowledged, then a full 0xFF frame arrives.
    send_frame(8'h3C, 1'b0);
    check("3c_value",   32'(value),   32'h3C);
    check("3c_valid",   32'(valid),   32'h1);
    check("3c_overrun", 32'(overrun), 32'h0);
    send_frame(8'hFF, 1'b0);
    check("ff_value_kept", 32'(value),   32'h3C);
    check("ff_valid",      32'(valid),   32'h1);
    check("ff_overrun",    32'(overrun), 32'h1);
    // ack on the completion edge loads the new word and leaves overrun alone.
    send_frame(8'h81, 1'b1);
    check("81_ovr_value",   32'(value),   32'h81);
    check("81_ovr_valid",   32'(valid),   32'h1);
    check("81_ovr_overrun", 32'(overrun), 32'h1);
    ack_once();
    check("ovr_ack_valid",   32'(valid),   32'h0);
    check("ovr_ack_overrun", 32'(overrun), 32'h0);

    // ack on the completion edge of 0x81 while 0x3C is still valid.
    send_frame(8'h3C, 1'b0);
    send_frame(8'h81, 1'b1);
    check("81_value",   32'(value),   32'h81);
    check("81_valid",   32'(valid),   32'h1);
    check("81_overrun", 32'(overrun), 32'h0);
    ack_once();
    check("81_ack_valid", 32'(valid), 32'h0);

    // Restart after 4 bits, then a full 0x5A frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse = 1'b1;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort4_valid", 32'(valid), 32'h0);
    check("abort4_busy",  32'(busy),  32'h1);
    shift_bits(8'h5A, 1'b0);
    check("5a_value", 32'(value), 32'h5A);
    check("5a_valid", 32'(valid), 32'h1);
    ack_once();

    // Restart on the edge that would otherwise have completed the frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < FRAME_LEN - 1; k++) begin
      pulse = 1'b1;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_last_valid", 32'(valid), 32'h0);
    check("abort_last_busy",  32'(busy),  32'h1);
    shift_bits(8'hC3, 1'b0);
    check("c3_value", 32'(value), 32'hC3);
    send_frame(8'h99, 1'b0);
    check("99_overrun", 32'(overrun), 32'h1);

    // Reset after 5 bits of a frame. Every output must clear asynchronously.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse = k[0];
      tick();
    end
    #2;
    Reset = 1'b0;
    #1;
    check("midrst_value",   32'(value),   32'h0);
    check("midrst_valid",   32'(valid),   32'h0);
    check("midrst_busy",    32'(busy),    32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    tick();
    Reset = 1'b1;
    // start is presented for the very first edge after release.
    send_frame(8'h0F, 1'b0);
    check("0f_value",   32'(value),   32'h0F);
    check("0f_valid",   32'(valid),   32'h1);
    check("0f_overrun", 32'(overrun), 32'h0);

    // Back-to-back: start in the cycle right after completion.
    send_frame(8'h12, 1'b1);
    check("b2b_value",   32'(value),   32'h12);
    check("b2b_valid",   32'(valid),   32'h1);
    check("b2b_overrun", 32'(overrun), 32'h0);
    ack_once();

`ifdef PULSE_RECEIVER_PARITY_EN
    flip_par = 1'b0;
    send_frame(8'h07, 1'b0);
    check("par_ok_value", 32'(value),      32'h07);
    check("par_ok_err",   32'(parity_err), 32'h0);
    flip_par = 1'b1;
    send_frame(8'h07, 1'b1);
    check("par_bad_valid", 32'(valid),      32'h1);
    check("par_bad_err",   32'(parity_err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
